// File: rtl/pr_avmm_bridge_pkg.sv
// -----------------------------------------------------------------------------
// pr_avmm_bridge_pkg
// Shared types for the local-memory PR-boundary Avalon-MM bridge.
//   t_avmm_cmd  : one request beat as held in the request skid buffer.
//                 Field widths are the widest configuration the bridge
//                 supports. Narrower instances zero-extend into the struct
//                 and slice back out on the master side.
//   ERR_*       : bit positions inside err_status.
// -----------------------------------------------------------------------------
package pr_avmm_bridge_pkg;

  localparam int unsigned CMD_ADDR_W = 27;
  localparam int unsigned CMD_DATA_W = 576;
  localparam int unsigned CMD_BC_W   = 7;

  localparam int unsigned ERR_RD_UNDERFLOW = 0;
  localparam int unsigned ERR_ZERO_BURST   = 1;

  typedef struct packed {
    logic                    read;
    logic                    write;
    logic [CMD_ADDR_W-1:0]   address;
    logic [CMD_BC_W-1:0]     burstcount;
    logic [CMD_DATA_W-1:0]   writedata;
    logic [CMD_DATA_W/8-1:0] byteenable;
  } t_avmm_cmd;

endpackage

// File: rtl/pr_avmm_skid_buf.sv
// -----------------------------------------------------------------------------
// pr_avmm_skid_buf
// Two-entry valid/ready skid buffer. Entries are registers, so an accepted
// beat appears on the output one cycle later. in_ready is a registered
// "not full" flag, which keeps the upstream stall free of combinational paths
// from out_ready.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is 0 during reset)
//   in_data             beat to store
//   out_valid/out_ready downstream handshake; head pops on valid & ready
//   out_data            head entry
// -----------------------------------------------------------------------------
module pr_avmm_skid_buf
  import pr_avmm_bridge_pkg::*;
#(
  parameter type T = t_avmm_cmd
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic [1:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  T           ent0_q, ent0_d;
  T           ent1_q, ent1_d;
  logic       push, pop;
  logic [1:0] cnt_after_pop;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    push          = in_valid & ~full_q;
    pop           = (cnt_q != 2'd0) & out_ready;
    cnt_after_pop = cnt_q - {1'b0, pop};
    // Entry 0 is always the head; a pop shifts entry 1 forward.
    if (pop) ent0_d = ent1_q;
    if (push) begin
      if (cnt_after_pop == 2'd0) ent0_d = in_data;
      else                       ent1_d = in_data;
    end
    cnt_d  = cnt_after_pop + {1'b0, push};
    full_d = (cnt_d == 2'd2);
  end

  // NOTE: sequential state uses non-blocking assignments only. The two data
  // entries are reset too: there are only two of them and the master-side
  // data pins must read 0 out of reset. A deeper storage array would be left
  // unreset and qualified by the count instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      full_q <= 1'b1;  // stall upstream while in reset
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign in_ready  = ~full_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = ent0_q;

endmodule

// File: rtl/pr_avmm_credit_bridge.sv
// -----------------------------------------------------------------------------
// pr_avmm_credit_bridge
// Registered Avalon-MM stage on the AFU side of the local-memory PR boundary.
// The s_* slave port faces AFU logic and the m_* master port faces the FIU.
// Requests go through a 2-entry skid buffer. A read is only issued when its
// beats fit in the MAX_RD_BEATS credit budget, so FIU read data can never
// overrun AFU-side buffering. Read responses and the ECC interrupt are
// retimed by one register.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   s_read/s_write/s_address/s_burstcount/s_writedata/s_byteenable  AFU cmd
//   s_waitrequest                    registered skid-buffer-full stall
//   s_readdata/s_readdatavalid       registered FIU read data
//   s_ecc_interrupt                  registered copy of m_ecc_interrupt
//   m_*                              FIU-facing mirror of the above
//   err_status                       [0] read underflow, [1] zero burstcount
// Configuration macro: PR_AVMM_BRIDGE_ERR_CHK_EN enables the sticky
// err_status checkers. When it is undefined, err_status is tied to 0.
// -----------------------------------------------------------------------------
module pr_avmm_credit_bridge
  import pr_avmm_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH       = 27,
  parameter int DATA_WIDTH       = 576,
  parameter int BURSTCOUNT_WIDTH = 7,
  parameter int MAX_RD_BEATS     = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        s_waitrequest,
  input  logic                        s_read,
  input  logic                        s_write,
  input  logic [ADDR_WIDTH-1:0]       s_address,
  input  logic [BURSTCOUNT_WIDTH-1:0] s_burstcount,
  input  logic [DATA_WIDTH-1:0]       s_writedata,
  input  logic [DATA_WIDTH/8-1:0]     s_byteenable,
  output logic [DATA_WIDTH-1:0]       s_readdata,
  output logic                        s_readdatavalid,
  output logic                        s_ecc_interrupt,
  input  logic                        m_waitrequest,
  output logic                        m_read,
  output logic                        m_write,
  output logic [ADDR_WIDTH-1:0]       m_address,
  output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]       m_writedata,
  output logic [DATA_WIDTH/8-1:0]     m_byteenable,
  input  logic [DATA_WIDTH-1:0]       m_readdata,
  input  logic                        m_readdatavalid,
  input  logic                        m_ecc_interrupt,
  output logic [1:0]                  err_status
);

  localparam int CNT_W = $clog2(MAX_RD_BEATS + 1);
  localparam int SUM_W = CNT_W + 1;

  if (MAX_RD_BEATS < (1 << (BURSTCOUNT_WIDTH - 1))) begin : g_credit_too_small
    $error("MAX_RD_BEATS must be at least the largest burst");
  end
  if (ADDR_WIDTH > CMD_ADDR_W || DATA_WIDTH > CMD_DATA_W ||
      BURSTCOUNT_WIDTH > CMD_BC_W) begin : g_width_too_large
    $error("bridge widths exceed t_avmm_cmd field widths");
  end

  t_avmm_cmd                   cmd_in, head;
  logic                        s_ready, head_valid, head_ready;
  logic [BURSTCOUNT_WIDTH-1:0] head_bc, head_beats;
  logic [SUM_W-1:0]            rd_sum;
  logic                        rd_issue, wr_issue, rd_ret;

  logic [CNT_W-1:0]            rd_out_q, rd_out_d;
  logic [BURSTCOUNT_WIDTH-1:0] wr_beats_q, wr_beats_d;
  logic [DATA_WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        ecc_q, ecc_d;

  always_comb begin
    cmd_in            = '0;
    cmd_in.read       = s_read;
    cmd_in.write      = s_write;
    cmd_in.address    = CMD_ADDR_W'(s_address);
    cmd_in.burstcount = CMD_BC_W'(s_burstcount);
    cmd_in.writedata  = CMD_DATA_W'(s_writedata);
    cmd_in.byteenable = (CMD_DATA_W/8)'(s_byteenable);
  end

  pr_avmm_skid_buf #(.T(t_avmm_cmd)) u_req_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_read | s_write),
    .in_ready  (s_ready),
    .in_data   (cmd_in),
    .out_valid (head_valid),
    .out_ready (head_ready),
    .out_data  (head)
  );

  assign s_waitrequest = ~s_ready;

  always_comb begin
    head_bc    = head.burstcount[BURSTCOUNT_WIDTH-1:0];
    // A zero burstcount is forwarded as-is but costs one beat of credit.
    head_beats = (head_bc == '0) ? BURSTCOUNT_WIDTH'(1) : head_bc;
    rd_sum     = SUM_W'(rd_out_q) + SUM_W'(head_beats);
    // Reads wait for any open write burst to finish, then for credit.
    m_read     = head_valid & head.read & (wr_beats_q == '0) &
                 (rd_sum <= SUM_W'(MAX_RD_BEATS));
    m_write    = head_valid & head.write;
    head_ready = (m_read | m_write) & ~m_waitrequest;
    rd_issue   = m_read & ~m_waitrequest;
    wr_issue   = m_write & ~m_waitrequest;
    // Returns with nothing outstanding (e.g. after a reset) do not decrement.
    rd_ret     = m_readdatavalid & (rd_out_q != '0);

    rd_out_d = rd_out_q + (rd_issue ? CNT_W'(head_beats) : '0) - CNT_W'(rd_ret);

    wr_beats_d = wr_beats_q;
    if (wr_issue) begin
      if (wr_beats_q == '0) wr_beats_d = head_beats - BURSTCOUNT_WIDTH'(1);
      else                  wr_beats_d = wr_beats_q - BURSTCOUNT_WIDTH'(1);
    end

    rsp_data_d  = m_readdata;
    rsp_valid_d = m_readdatavalid;
    ecc_d       = m_ecc_interrupt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_out_q    <= '0;
      wr_beats_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ecc_q       <= 1'b0;
    end else begin
      rd_out_q    <= rd_out_d;
      wr_beats_q  <= wr_beats_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ecc_q       <= ecc_d;
    end
  end

  assign m_address       = head.address[ADDR_WIDTH-1:0];
  assign m_burstcount    = head_bc;
  assign m_writedata     = head.writedata[DATA_WIDTH-1:0];
  assign m_byteenable    = head.byteenable[DATA_WIDTH/8-1:0];
  assign s_readdata      = rsp_data_q;
  assign s_readdatavalid = rsp_valid_q;
  assign s_ecc_interrupt = ecc_q;

`ifdef PR_AVMM_BRIDGE_ERR_CHK_EN
  // The zero-burst checker needs to know which accepted beat starts a write
  // burst, so it tracks write beats on the slave side independently.
  logic [BURSTCOUNT_WIDTH-1:0] acc_wr_q, acc_wr_d;
  logic [1:0]                  err_q, err_d;
  logic                        s_accept, s_first;

  always_comb begin
    s_accept = (s_read | s_write) & ~s_waitrequest;
    s_first  = s_read | (acc_wr_q == '0);
    acc_wr_d = acc_wr_q;
    if (s_accept & s_write) begin
      if (acc_wr_q != '0)             acc_wr_d = acc_wr_q - BURSTCOUNT_WIDTH'(1);
      else if (s_burstcount != '0)    acc_wr_d = s_burstcount - BURSTCOUNT_WIDTH'(1);
    end
    err_d = err_q;
    if (m_readdatavalid & (rd_out_q == '0))          err_d[ERR_RD_UNDERFLOW] = 1'b1;
    if (s_accept & s_first & (s_burstcount == '0))   err_d[ERR_ZERO_BURST]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_wr_q <= '0;
      err_q    <= 2'b00;
    end else begin
      acc_wr_q <= acc_wr_d;
      err_q    <= err_d;
    end
  end

  assign err_status = err_q;
`else
  assign err_status = 2'b00;
`endif

endmodule

// File: tb/tb_pr_avmm_credit_bridge.sv
// -----------------------------------------------------------------------------
// tb_pr_avmm_credit_bridge
// Directed bench for pr_avmm_credit_bridge (MAX_RD_BEATS=8, 4-bit burstcount).
// Each issued command pushes the expected master-side beat into exp_iss, and
// each FIU return pushes the expected slave-side data and arrival cycle into
// exp_rsp. A negedge monitor pops and compares whenever the DUT presents a
// beat. Honours PR_AVMM_BRIDGE_ERR_CHK_EN for the err_status expectations.
// -----------------------------------------------------------------------------
module tb_pr_avmm_credit_bridge;

  localparam int AW   = 27;
  localparam int DW   = 576;
  localparam int BCW  = 4;
  localparam int MAXB = 8;
  localparam int BEW  = DW / 8;

`ifdef PR_AVMM_BRIDGE_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           s_waitrequest, s_read, s_write;
  logic [AW-1:0]  s_address, m_address;
  logic [BCW-1:0] s_burstcount, m_burstcount;
  logic [DW-1:0]  s_writedata, s_readdata, m_writedata, m_readdata;
  logic [BEW-1:0] s_byteenable, m_byteenable;
  logic           s_readdatavalid, s_ecc_interrupt;
  logic           m_waitrequest, m_read, m_write, m_readdatavalid, m_ecc_interrupt;
  logic [1:0]     err_status;

  pr_avmm_credit_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BCW), .MAX_RD_BEATS(MAXB)
  ) dut (
    .clk(clk), .reset(reset),
    .s_waitrequest(s_waitrequest), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_burstcount(s_burstcount),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_ecc_interrupt(s_ecc_interrupt),
    .m_waitrequest(m_waitrequest), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_burstcount(m_burstcount),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_ecc_interrupt(m_ecc_interrupt), .err_status(err_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit             rd;
    bit             wr;
    logic [AW-1:0]  addr;
    logic [BCW-1:0] bc;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
  } iss_t;

  typedef struct {
    logic [DW-1:0] data;
    int            at;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  int   iss_cyc[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: master-side issues and slave-side responses.
  always @(negedge clk) begin
    iss_t e;
    rsp_t r;
    if (!reset && (m_read || m_write) && !m_waitrequest) begin
      iss_cyc.push_back(cyc);
      if (exp_iss.size() == 0) begin
        check("issue_unexpected", m_read | m_write, 1'b0);
      end else begin
        e = exp_iss.pop_front();
        check("iss_read",  m_read,       e.rd);
        check("iss_write", m_write,      e.wr);
        check("iss_addr",  m_address,    e.addr);
        check("iss_bc",    m_burstcount, e.bc);
        check("iss_data",  m_writedata,  e.data);
        check("iss_be",    m_byteenable, e.be);
      end
    end
    if (s_readdatavalid) begin
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected", s_readdatavalid, 1'b0);
      end else begin
        r = exp_rsp.pop_front();
        check("rsp_data",    s_readdata, r.data);
        check("rsp_latency", cyc,        r.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat on the slave port and hold it until accepted.
  task automatic send(input bit rd, input logic [AW-1:0] a, input logic [BCW-1:0] bc,
                      input logic [DW-1:0] d, input logic [BEW-1:0] be, input bit expect_issue);
    int   n = 0;
    iss_t e;
    s_read = rd; s_write = !rd; s_address = a; s_burstcount = bc;
    s_writedata = d; s_byteenable = be;
    while (s_waitrequest && n < 100) begin
      tick();
      n++;
    end
    check("send_accept", s_waitrequest, 1'b0);
    if (expect_issue) begin
      e.rd = rd; e.wr = !rd; e.addr = a; e.bc = bc; e.data = d; e.be = be;
      exp_iss.push_back(e);
    end
    tick();
    s_read = 1'b0; s_write = 1'b0;
  endtask

  // FIU returns n read beats on consecutive cycles.
  task automatic fiu_return(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      rsp_t r;
      m_readdatavalid = 1'b1;
      m_readdata      = base + DW'(i);
      r.data = m_readdata;
      r.at   = cyc + 1;
      exp_rsp.push_back(r);
      tick();
    end
    m_readdatavalid = 1'b0;
  endtask

  // FIU answers each single-beat read issue one cycle later.
  task automatic auto_responder(input int ncyc, input logic [DW-1:0] base);
    int k = 0;
    for (int i = 0; i < ncyc; i++) begin
      bit iss;
      @(negedge clk);
      iss = m_read && !m_waitrequest;
      @(posedge clk);
      #1;
      m_readdatavalid = iss;
      if (iss) begin
        rsp_t r;
        m_readdata = base + DW'(k);
        k++;
        r.data = m_readdata;
        r.at   = cyc + 1;
        exp_rsp.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    m_readdatavalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    s_read = 0; s_write = 0; s_address = '0; s_burstcount = '0;
    s_writedata = '0; s_byteenable = '0;
    m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0; m_ecc_interrupt = 0;
    reset = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_s_waitrequest", s_waitrequest, 1'b1);
    check("rst_m_read",        m_read,        1'b0);
    check("rst_m_write",       m_write,       1'b0);
    check("rst_m_address",     m_address,     '0);
    check("rst_s_rdv",         s_readdatavalid, 1'b0);
    check("rst_s_ecc",         s_ecc_interrupt, 1'b0);
    check("rst_err",           err_status,    2'b00);
    reset = 1'b0;
    tick();
    check("post_rst_waitrequest", s_waitrequest, 1'b0);

    // 1: three burst-4 reads against an 8-beat budget
    send(1, 27'h100, 4'd4, '0, '0, 1);
    send(1, 27'h104, 4'd4, '0, '0, 1);
    send(1, 27'h108, 4'd4, '0, '0, 1);
    repeat (4) tick();
    check("t1_third_held",  m_read, 1'b0);
    check("t1_pending",     exp_iss.size(), 1);
    fiu_return(1, 'h1000);
    repeat (2) tick();
    check("t1_held_after_1", m_read, 1'b0);
    fiu_return(2, 'h1001);
    tick();
    check("t1_held_after_3", m_read, 1'b0);
    fiu_return(1, 'h1003);
    check("t1_open_after_4", m_read, 1'b1);
    fiu_return(8, 'h2000);
    repeat (2) tick();

    // 2: write burst of 4 under toggling waitrequest, then a read
    fork
      begin
        send(0, 27'h200, 4'd4, 'hA0, 72'h0F, 1);
        send(0, 27'h200, 4'd4, 'hA1, 72'hF0, 1);
        send(0, 27'h200, 4'd4, 'hA2, 72'h3C, 1);
        send(0, 27'h200, 4'd4, 'hA3, 72'hC3, 1);
        send(1, 27'h300, 4'd1, '0, '0, 1);
      end
      begin
        repeat (16) begin
          m_waitrequest = ~m_waitrequest;
          tick();
        end
        m_waitrequest = 1'b0;
      end
    join
    repeat (4) tick();
    check("t2_drained", exp_iss.size(), 0);
    fiu_return(1, 'h3000);
    repeat (2) tick();

    // 3: sustained single-beat reads with 1 beat/clk returns, plus ECC
    iss_cyc.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send(1, AW'('h400 + i), 4'd1, '0, '0, 1);
      end
      auto_responder(14, 'h4000);
    join
    repeat (3) tick();
    check("t3_issues", iss_cyc.size(), 6);
    check("t3_rate", (iss_cyc.size() >= 6) ? iss_cyc[5] - iss_cyc[0] : -1, 5);
    m_ecc_interrupt = 1'b1;
    tick();
    m_ecc_interrupt = 1'b0;
    check("ecc_set", s_ecc_interrupt, 1'b1);
    tick();
    check("ecc_clear", s_ecc_interrupt, 1'b0);

    // 4: full budget, returns free credit with issue and return in one cycle
    send(1, 27'h500, 4'd4, '0, '0, 1);
    send(1, 27'h504, 4'd4, '0, '0, 1);
    send(1, 27'h508, 4'd1, '0, '0, 1);
    send(1, 27'h509, 4'd1, '0, '0, 1);
    repeat (3) tick();
    check("t4_held",    m_read, 1'b0);
    check("t4_pending", exp_iss.size(), 2);
    iss_cyc.delete();
    fiu_return(10, 'h5000);
    repeat (2) tick();
    check("t4_issued", iss_cyc.size(), 2);
    check("t4_no_bubble", (iss_cyc.size() >= 2) ? iss_cyc[1] - iss_cyc[0] : -1, 1);
    // Counter must be back to exactly 0: a full burst fits, one more beat does not.
    send(1, 27'h600, 4'd8, '0, '0, 1);
    send(1, 27'h610, 4'd1, '0, '0, 1);
    repeat (3) tick();
    check("t4_probe_pending", exp_iss.size(), 1);
    check("t4_probe_held",    m_read, 1'b0);
    fiu_return(9, 'h6000);
    repeat (3) tick();

    // 5: reset with 3 beats in flight and a held read in the skid buffer
    send(1, 27'h700, 4'd3, '0, '0, 1);
    send(1, 27'h704, 4'd8, '0, '0, 0);
    repeat (2) tick();
    check("t5_held", m_read, 1'b0);
    reset = 1'b1;
    tick();
    check("t5_rst_waitrequest", s_waitrequest, 1'b1);
    check("t5_rst_m_read",      m_read, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_post_waitrequest", s_waitrequest, 1'b0);
    fiu_return(3, 'h7000);
    tick();
    check("t5_err_underflow", err_status, ERR_EN ? 2'b01 : 2'b00);
    send(1, 27'h720, 4'd8, '0, '0, 1);
    send(1, 27'h728, 4'd1, '0, '0, 1);
    repeat (3) tick();
    check("t5_probe_pending", exp_iss.size(), 1);
    check("t5_probe_held",    m_read, 1'b0);
    fiu_return(9, 'h7100);
    repeat (3) tick();

    // 6: zero-burstcount commands
    send(1, 27'h800, 4'd0, '0, '0, 1);
    repeat (2) tick();
    fiu_return(1, 'h8000);
    send(0, 27'h900, 4'd0, 'hB0, 72'hFF, 1);
    send(0, 27'h904, 4'd1, 'hB1, 72'h01, 1);
    send(1, 27'h908, 4'd1, '0, '0, 1);
    repeat (3) tick();
    check("t6_drained", exp_iss.size(), 0);
    check("t6_err_both", err_status, ERR_EN ? 2'b11 : 2'b00);
    fiu_return(1, 'h9000);
    repeat (3) tick();
    check("t6_err_held", err_status, ERR_EN ? 2'b11 : 2'b00);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("t6_err_cleared", err_status, 2'b00);

    repeat (5) tick();
    check("end_iss_queue", exp_iss.size(), 0);
    check("end_rsp_queue", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
